// File: rtl/captura_operandos.sv
// Operand-entry front end for the 4-bit adder. It synchronises the switches and debounces
// KEY_ENTER, then steps through A and B/Te capture, with valid high once all three are held.
module captura_operandos #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] SW_DATA,
    input  logic       SW_TE,
    input  logic       KEY_ENTER,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Te,
    output logic       valid,
    output logic [2:0] LEDG
);

    localparam int unsigned RelW = CNT_W + 1;
    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The synchroniser preload of 1 accounts for the two extra cycles.
    localparam logic [RelW-1:0]  ArmLast = RelW'(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {StEsperaA, StEsperaB, StPronto} state_e;

    state_e           state_q, state_d;
    logic [3:0]       sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic             te_meta_q, te_meta_d, te_sync_q, te_sync_d;
    logic             key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic             acc_q, acc_d, acc_dly_q, acc_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RelW-1:0]  rel_cnt_q, rel_cnt_d;
    logic             armed_q, armed_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic             te_q, te_d, valid_q, valid_d;
    logic             press;

    always_comb begin
        sw_meta_d  = SW_DATA;
        sw_sync_d  = sw_meta_q;
        te_meta_d  = SW_TE;
        te_sync_d  = te_meta_q;
        key_meta_d = KEY_ENTER;
        key_sync_d = key_meta_q;

        acc_d     = acc_q;
        acc_dly_d = acc_q;
        cnt_d     = '0;
        if (key_sync_q != acc_q) begin
            if (cnt_q == DebLast) begin
                acc_d = key_sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A key held through reset must be seen released and stable before presses count.
        armed_d   = armed_q;
        rel_cnt_d = '0;
        if (!armed_q && key_sync_q) begin
            if (rel_cnt_q == ArmLast) begin
                armed_d = 1'b1;
            end else begin
                rel_cnt_d = rel_cnt_q + 1'b1;
            end
        end
    end

    assign press = armed_q & acc_dly_q & ~acc_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        te_d    = te_q;
        if (press) begin
            unique case (state_q)
                StEsperaA, StPronto: begin
                    a_d     = sw_sync_q;
                    state_d = StEsperaB;
                end
                StEsperaB: begin
                    b_d     = sw_sync_q;
                    te_d    = te_sync_q;
                    state_d = StPronto;
                end
                default: state_d = StEsperaA;
            endcase
        end
        valid_d = (state_d == StPronto);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            te_meta_q  <= 1'b0;
            te_sync_q  <= 1'b0;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            acc_q      <= 1'b1;
            acc_dly_q  <= 1'b1;
            cnt_q      <= '0;
            rel_cnt_q  <= '0;
            armed_q    <= 1'b0;
            state_q    <= StEsperaA;
            a_q        <= '0;
            b_q        <= '0;
            te_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            te_meta_q  <= te_meta_d;
            te_sync_q  <= te_sync_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            acc_q      <= acc_d;
            acc_dly_q  <= acc_dly_d;
            cnt_q      <= cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            te_q       <= te_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        LEDG = 3'b001;
        unique case (state_q)
            StEsperaA: LEDG = 3'b001;
            StEsperaB: LEDG = 3'b010;
            StPronto:  LEDG = 3'b100;
            default:   LEDG = 3'b001;
        endcase
    end

    assign A     = a_q;
    assign B     = b_q;
    assign Te    = te_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos with a short debounce window (4 cycles, 3-bit counter).
module tb_captura_operandos;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_data;
    logic       sw_te;
    logic       key;
    logic [3:0] a, b;
    logic       te, valid;
    logic [2:0] ledg;

    int n_cmp = 0;
    int n_err = 0;

    captura_operandos #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW_DATA  (sw_data),
        .SW_TE    (sw_te),
        .KEY_ENTER(key),
        .A        (a),
        .B        (b),
        .Te       (te),
        .valid    (valid),
        .LEDG     (ledg)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        key = 1'b0;
        tick(hold);
        key = 1'b1;
        tick(12);
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic ete, input logic ev, input logic [2:0] el);
        check_eq({tag, ".A"}, 32'(a), 32'(ea));
        check_eq({tag, ".B"}, 32'(b), 32'(eb));
        check_eq({tag, ".Te"}, 32'(te), 32'(ete));
        check_eq({tag, ".valid"}, 32'(valid), 32'(ev));
        check_eq({tag, ".LEDG"}, 32'(ledg), 32'(el));
    endtask

    initial begin
        rst     = 1'b1;
        sw_data = 4'd0;
        sw_te   = 1'b0;
        key     = 1'b1;
        tick(3);
        check_all("in_reset", 4'd0, 4'd0, 1'b0, 1'b0, 3'b001);
        rst = 1'b0;
        tick(20);
        check_all("idle", 4'd0, 4'd0, 1'b0, 1'b0, 3'b001);

        // Two clean presses: A=9, then B=7 with carry-in.
        sw_data = 4'd9;
        tick(4);
        press(10);
        check_all("press_a", 4'd9, 4'd0, 1'b0, 1'b0, 3'b010);
        sw_data = 4'd7;
        sw_te   = 1'b1;
        tick(4);
        press(10);
        check_all("press_b", 4'd9, 4'd7, 1'b1, 1'b1, 3'b100);
        check_eq("sum", 32'(a) + 32'(b) + 32'(te), 32'd17);

        // Switch changes while waiting must not disturb the registers.
        sw_data = 4'd14;
        sw_te   = 1'b0;
        tick(10);
        check_all("sw_idle", 4'd9, 4'd7, 1'b1, 1'b1, 3'b100);

        // New entry from PRONTO: A replaced, B/Te hold.
        sw_data = 4'd3;
        tick(4);
        press(10);
        check_all("restart", 4'd3, 4'd7, 1'b1, 1'b0, 3'b010);
        sw_data = 4'd5;
        tick(4);
        press(10);
        check_all("press_b2", 4'd3, 4'd5, 1'b0, 1'b1, 3'b100);

        // Bouncy press: exactly one capture, timed from the final fall.
        sw_data = 4'd12;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            key = 1'b0;
            tick(2);
            key = 1'b1;
            tick(2);
        end
        check_all("bounce_none", 4'd3, 4'd5, 1'b0, 1'b1, 3'b100);
        key = 1'b0;
        tick(5);
        check_eq("bounce_early.A", 32'(a), 32'd3);
        tick(3);
        check_eq("bounce_late.A", 32'(a), 32'd12);
        sw_data = 4'd1;
        tick(20);
        key = 1'b1;
        tick(12);
        check_all("bounce_once", 4'd12, 4'd5, 1'b0, 1'b0, 3'b010);

        // Long hold in ESPERA_A yields one event only.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(20);
        check_all("reset2", 4'd0, 4'd0, 1'b0, 1'b0, 3'b001);
        sw_data = 4'd6;
        tick(4);
        key = 1'b0;
        tick(20);
        sw_data = 4'd2;
        tick(80);
        check_all("hold", 4'd6, 4'd0, 1'b0, 1'b0, 3'b010);
        key = 1'b1;
        tick(12);
        check_all("hold_rel", 4'd6, 4'd0, 1'b0, 1'b0, 3'b010);

        // Reset mid-operation with key held: no event until release and re-press.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(20);
        sw_data = 4'd4;
        tick(4);
        key = 1'b0;
        tick(15);
        check_eq("pre_rst.LEDG", 32'(ledg), 32'b010);
        rst = 1'b1;
        tick(1);
        check_all("rst_held", 4'd0, 4'd0, 1'b0, 1'b0, 3'b001);
        rst = 1'b0;
        tick(10);
        check_all("held_after", 4'd0, 4'd0, 1'b0, 1'b0, 3'b001);
        key = 1'b1;
        tick(15);
        check_all("released", 4'd0, 4'd0, 1'b0, 1'b0, 3'b001);
        sw_data = 4'd8;
        tick(4);
        press(10);
        check_all("repress", 4'd8, 4'd0, 1'b0, 1'b0, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
Upstream operand-entry stage for the 4-bit adder datapath on the DE2 board. One set of 4 data switches and one push-button replace the two separate switch banks. The block debounces the button and sequences operand A, then operand B plus carry-in Te, into holding registers. It then presents them with a valid flag to the adder/decoder path, which drives HEX1/HEX0.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples required before a key level change is accepted (10 ms at 50 MHz); must be >= 1.
CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge.
RESET  input  1  synchronous, active-high reset.
SW_DATA  input  4  operand data switches; asynchronous, quasi-static.
SW_TE  input  1  carry-in switch; asynchronous.
KEY_ENTER  input  1  push-button, active-low (0 = pressed); asynchronous, bouncy.
A  output  4  captured operand A.
B  output  4  captured operand B.
Te  output  1  captured carry-in.
valid  output  1  high while A, B and Te form a complete operand set.
LEDG  output  3  one-hot state indicator: [0] ESPERA_A, [1] ESPERA_B, [2] PRONTO.

Behaviour:
- Synchronizers:
  - KEY_ENTER, SW_DATA and SW_TE each pass through a 2-FF synchronizer.
  - Synchronizer flops reset to KEY=1 and SW=0.
- Debounce:
  - An accepted key level register resets to 1.
  - A counter increments while the synchronized key differs from the accepted level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level takes the synchronized value and the counter clears.
  - Any bounce before that point restarts the count.
- Press event:
  - One-cycle internal pulse `press`, asserted in the cycle after the accepted level goes 1->0.
  - A release (0->1) generates no event.
  - Holding the key produces exactly one event.
- FSM: states ESPERA_A, ESPERA_B, PRONTO; reset state ESPERA_A.
  - ESPERA_A + press: A <= synchronized SW_DATA; go to ESPERA_B.
  - ESPERA_B + press: B <= synchronized SW_DATA, Te <= synchronized SW_TE; go to PRONTO.
  - PRONTO + press: A <= synchronized SW_DATA, B and Te hold their old values; go to ESPERA_B. The press starts a new entry without an extra idle press.
  - With no press, state and all registers hold.
- valid:
  - Registered; equals 1 exactly when state == PRONTO.
  - Rises on the same edge that captures B/Te.
  - Falls on the edge that captures a new A.
- A, B, Te change only on a press edge. They are registered outputs and never glitch with SW changes.
- LEDG is one-hot decoded from state. It is never all-zero, including immediately after reset.
- Reset values: A=0, B=0, Te=0, valid=0, LEDG=3'b001. The debounce counter clears and the accepted level goes to 1.
- Reset asserted mid-operation (any state, key held or bouncing):
  - Everything returns to reset values on that edge.
  - A key held through reset release must be released and debounced before any new event; no event is generated at reset release.
- Switch changes between presses have no effect. The value sampled is the 2-FF-synchronized SW at the press cycle.

Test Plan:
(DEBOUNCE_CYCLES=4, CNT_W=3 for all scenarios.)
1. Reset, then idle 20 cycles -> A=0, B=0, Te=0, valid=0, LEDG=001.
2. SW_DATA=4'd9, clean press of 10 cycles; then SW_DATA=4'd7, SW_TE=1, clean press -> after the first press A=9, LEDG=010. After the second, B=7, Te=1, valid=1, LEDG=100; the downstream adder shows 17.
3. Key bounces 0/1 every 2 cycles for 12 cycles, then stays 0 -> exactly one capture. A updates 2 sync + 4 debounce + 1 cycles after the last bounce ends.
4. In PRONTO (A=9, B=7, Te=1), SW_DATA=4'd3, press -> valid falls, A=3, B=7, Te=1 hold, LEDG=010.
5. Key held low for 100 cycles in ESPERA_A -> exactly one transition to ESPERA_B; no further capture until release plus a new press.
6. RESET asserted for 1 cycle while in ESPERA_B with key held low, then key held 10 more cycles -> reset values restored, state stays ESPERA_A, no capture until release and re-press.
